// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: decoded control bundle and ALUOp encodings.
package riscv_pkg;

  // ALUOp encodings consumed by the ALU controller in execute.
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_JL  = 2'b11;

  // Decoded control bundle carried from decode into execute.
  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // All-zero control word used for bubbles and reset; it has no side effects.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: the instruction held in ID/EX is a load whose
// destination (other than x0) is a source of the instruction sitting in decode.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              in_valid_i,
  input  logic              out_valid_i,
  input  logic              mem_read_i,
  input  logic [REG_AW-1:0] held_rd_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  output logic              hazard_o
);

  logic rd_nonzero;
  logic rd_match;

  assign rd_nonzero = (held_rd_i != '0);
  assign rd_match   = (held_rd_i == dec_rs1_i) || (held_rd_i == dec_rs2_i);
  assign hazard_o   = in_valid_i && out_valid_i && mem_read_i && rd_nonzero && rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall and flush.
// Optional feature: define IDEX_STALL_CNT_EN to add the 32-bit saturating
// stall_cnt output counting load-use stall cycles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  ctrl_t             in_ctrl,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output ctrl_t             out_ctrl,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  logic hazard;
  logic take_in;
  logic take_bubble;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .in_valid_i  (in_valid),
    .out_valid_i (valid_q),
    .mem_read_i  (ctrl_q.mem_read),
    .held_rd_i   (rd_q),
    .dec_rs1_i   (in_rs1),
    .dec_rs2_i   (in_rs2),
    .hazard_o    (hazard)
  );

  // Accept only when not flushing, not stalled on a load-use, and the slot frees up.
  assign in_ready = !flush && !hazard && (!valid_q || out_ready);

  // Pick the next action: flush beats everything, then a transfer, then a
  // drain to bubble once execute consumed the held entry; otherwise hold.
  always_comb begin
    take_in     = 1'b0;
    take_bubble = 1'b0;
    if (flush) begin
      take_bubble = 1'b1;
    end else if (in_valid && in_ready) begin
      take_in = 1'b1;
    end else if (valid_q && out_ready) begin
      take_bubble = 1'b1;
    end else begin
      take_in     = 1'b0;
      take_bubble = 1'b0;
    end
  end

  // Next-state mux: load decode slot, load an all-zero bubble, or hold.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    if (take_in) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      pc_d    = in_pc;
      rd1_d   = in_rd1;
      rd2_d   = in_rd2;
      imm_d   = in_imm;
      rs1_d   = in_rs1;
      rs2_d   = in_rs2;
      rd_d    = in_rd;
    end else if (take_bubble) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      pc_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
    end else begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end
  end

  // Pipeline register; reset discards any held instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_pc    = pc_q;
  assign out_rd1   = rd1_q;
  assign out_rd2   = rd2_q;
  assign out_imm   = imm_q;
  assign out_rs1   = rs1_q;
  assign out_rs2   = rs2_q;
  assign out_rd    = rd_q;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count load-use stall cycles that are not overridden by a flush; saturate.
  always_comb begin
    if (hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  ctrl_t       in_ctrl;
  logic [31:0] in_pc, in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  ctrl_t       out_ctrl;
  logic [31:0] out_pc, out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int pass_cnt;
  int total_cnt;
  int exp_stall;

  ctrl_t lw_c, add_c, addi_c, sub_c, or_c;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_pc     (in_pc),
    .in_rd1    (in_rd1),
    .in_rd2    (in_rd2),
    .in_imm    (in_imm),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ctrl  (out_ctrl),
    .out_pc    (out_pc),
    .out_rd1   (out_rd1),
    .out_rd2   (out_rd2),
    .out_imm   (out_imm),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .out_rd    (out_rd)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic rw, input logic mr, input logic m2r, input logic asrc);
    ctrl_t c;
    c            = '0;
    c.alu_op     = op;
    c.funct3     = f3;
    c.funct7     = f7;
    c.reg_write  = rw;
    c.mem_read   = mr;
    c.mem_to_reg = m2r;
    c.alu_src    = asrc;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    in_valid = v;
    in_ctrl  = c;
    in_pc    = pc;
    in_rd1   = pc + 32'h0000_1000;
    in_rd2   = pc + 32'h0000_2000;
    in_imm   = imm;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    #3;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_ctrl !== CTRL_NOP) $display("FAIL rst_ctrl: got %h want 0", out_ctrl); else pass_cnt++;
    total_cnt++; if (out_pc !== 32'd0) $display("FAIL rst_pc: got %h want 0", out_pc); else pass_cnt++;
`ifdef IDEX_STALL_CNT_EN
    total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL rst_stall: got %0d want 0", stall_cnt); else pass_cnt++;
`endif
    step(); step();
    rst_n = 1'b1;
    exp_stall = 0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_release_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_load_use();
    drive(1'b1, lw_c, 32'h100, 32'h4, 5'd2, 5'd0, 5'd5);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_accept_lw: got %0b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_ctrl !== lw_c) $display("FAIL lu_lw_ctrl: got %h want %h", out_ctrl, lw_c); else pass_cnt++;
    total_cnt++; if (out_rd1 !== 32'h1100) $display("FAIL lu_lw_rd1: got %h want 1100", out_rd1); else pass_cnt++;
    drive(1'b1, add_c, 32'h104, 32'h0, 5'd5, 5'd6, 5'd7);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL lu_stall_ready: got %0b want 0", in_ready); else pass_cnt++;
    step();
    exp_stall++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL lu_bubble_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_ctrl !== CTRL_NOP) $display("FAIL lu_bubble_ctrl: got %h want 0", out_ctrl); else pass_cnt++;
    total_cnt++; if (out_pc !== 32'd0) $display("FAIL lu_bubble_pc: got %h want 0", out_pc); else pass_cnt++;
`ifdef IDEX_STALL_CNT_EN
    total_cnt++; if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else pass_cnt++;
`endif
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_after_ready: got %0b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h104) $display("FAIL lu_add_out: got v=%0b pc=%h want v=1 pc=104", out_valid, out_pc); else pass_cnt++;
    total_cnt++; if (out_ctrl !== add_c || out_rd !== 5'd7) $display("FAIL lu_add_ctrl: got %h rd=%0d want %h rd=7", out_ctrl, out_rd, add_c); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL lu_drain: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_x0_no_stall();
    drive(1'b1, lw_c, 32'h200, 32'h8, 5'd3, 5'd0, 5'd0);
    step();
    drive(1'b1, add_c, 32'h204, 32'h0, 5'd0, 5'd0, 5'd8);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL x0_ready: got %0b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h204) $display("FAIL x0_out: got v=%0b pc=%h want v=1 pc=204", out_valid, out_pc); else pass_cnt++;
`ifdef IDEX_STALL_CNT_EN
    total_cnt++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL x0_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else pass_cnt++;
`endif
    idle();
    step();
  endtask

  task automatic test_backpressure();
    drive(1'b1, addi_c, 32'h300, 32'h7, 5'd1, 5'd0, 5'd9);
    step();
    out_ready = 1'b0;
    drive(1'b1, add_c, 32'h304, 32'h0, 5'd1, 5'd2, 5'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_imm !== 32'h7 || out_ctrl !== addi_c)
        $display("FAIL bp_hold[%0d]: got v=%0b pc=%h imm=%h ctrl=%h want v=1 pc=300 imm=7 ctrl=%h", i, out_valid, out_pc, out_imm, out_ctrl, addi_c);
      else pass_cnt++;
      step();
    end
    total_cnt++; if (out_pc !== 32'h300) $display("FAIL bp_hold_end: got pc=%h want 300", out_pc); else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_pc !== 32'h304 || out_rd !== 5'd10) $display("FAIL bp_next: got pc=%h rd=%0d want pc=304 rd=10", out_pc, out_rd); else pass_cnt++;
    idle();
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, lw_c, 32'h400, 32'h0, 5'd1, 5'd0, 5'd5);
    step();
    drive(1'b1, add_c, 32'h404, 32'h0, 5'd5, 5'd5, 5'd6);
    flush = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL fl_ready: got %0b want 0", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_NOP || out_pc !== 32'd0)
      $display("FAIL fl_bubble: got v=%0b ctrl=%h pc=%h want all 0", out_valid, out_ctrl, out_pc);
    else pass_cnt++;
`ifdef IDEX_STALL_CNT_EN
    total_cnt++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL fl_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else pass_cnt++;
`endif
    flush = 1'b0;
    drive(1'b1, lw_c, 32'h408, 32'h0, 5'd1, 5'd0, 5'd4);
    step();
    idle();
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_NOP) $display("FAIL fl_backpressured: got v=%0b ctrl=%h want 0", out_valid, out_ctrl); else pass_cnt++;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, sub_c, 32'h500, 32'h0, 5'd1, 5'd2, 5'd11);
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_ctrl.funct7 !== 7'b0100000 || out_ctrl.funct3 !== 3'b000 || out_ctrl.alu_op !== ALUOP_RI)
      $display("FAIL b2b_sub: got v=%0b ctrl=%h want v=1 ctrl=%h", out_valid, out_ctrl, sub_c);
    else pass_cnt++;
    drive(1'b1, or_c, 32'h504, 32'h0, 5'd3, 5'd4, 5'd12);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_ctrl.funct3 !== 3'b110 || out_ctrl.funct7 !== 7'b0 || out_pc !== 32'h504)
      $display("FAIL b2b_or: got v=%0b ctrl=%h pc=%h want v=1 ctrl=%h pc=504", out_valid, out_ctrl, out_pc, or_c);
    else pass_cnt++;
    total_cnt++; if (out_rd2 !== 32'h2504) $display("FAIL b2b_or_rd2: got %h want 2504", out_rd2); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, add_c, 32'h600, 32'h0, 5'd1, 5'd2, 5'd3);
    step();
    idle();
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL mr_pre_valid: got %0b want 1", out_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_ctrl !== CTRL_NOP || out_pc !== 32'd0)
      $display("FAIL mr_async: got v=%0b ctrl=%h pc=%h want all 0", out_valid, out_ctrl, out_pc);
    else pass_cnt++;
`ifdef IDEX_STALL_CNT_EN
    total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL mr_stall_cnt: got %0d want 0", stall_cnt); else pass_cnt++;
`endif
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mr_release: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_stall = 0;
    lw_c   = mk(ALUOP_MEM, 3'b010, 7'b0000000, 1'b1, 1'b1, 1'b1, 1'b1);
    add_c  = mk(ALUOP_RI,  3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0);
    addi_c = mk(ALUOP_MEM, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b1);
    sub_c  = mk(ALUOP_RI,  3'b000, 7'b0100000, 1'b1, 1'b0, 1'b0, 1'b0);
    or_c   = mk(ALUOP_RI,  3'b110, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_x0_no_stall();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
